mem_access_controller: RTL and testbench

Sequences every data-memory access issued by the Memory stage onto the single-port, doubleword-wide data_memory array. Handles LDUR/STUR size variants (byte, half, word, doubleword) and performs read-modify-write for sub-doubleword stores. Extracts and zero-extends sub-doubleword loads. Holds the pipeline via stall while an access is in flight.

---
 rtl/mem_access_controller_pkg.sv | 36 +++
 rtl/mem_access_controller_lane_merge.sv | 34 +++
 rtl/mem_access_controller.sv | 154 +++++++++++++++
 tb/tb_mem_access_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_controller_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_controller_pkg: size/state encodings and alignment helper
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_access_controller_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // An access is aligned when the low 'size' address bits are zero.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_controller_lane_merge.sv
// ----------------------------------------------------------------------------
// lane_merge: little-endian byte-lane store merge and zero-extended load extract
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lane_merge
  import mem_access_controller_pkg::*;
#(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0] buffer_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [2:0]      offset_i,
  input  logic [1:0]      size_i,
  output logic [WORD-1:0] merged_o,
  output logic [WORD-1:0] load_o
);

  logic [WORD-1:0] lane_mask;
  logic [WORD-1:0] field_mask;
  logic [5:0]      shamt;

  assign shamt      = {offset_i, 3'b000};
  assign lane_mask  = (size_i == SZ_D) ? '1
                    : ((WORD'(1) << (8 << size_i)) - WORD'(1));
  assign field_mask = lane_mask << shamt;

  assign merged_o = (buffer_i & ~field_mask) | ((wdata_i & lane_mask) << shamt);
  assign load_o   = (buffer_i >> shamt) & lane_mask;

endmodule

`default_nettype wire

// File: rtl/mem_access_controller.sv
// ----------------------------------------------------------------------------
// mem_access_controller: sequences sized loads/stores (with RMW) onto a
// single-port doubleword data memory. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int WORD        = 64,
  parameter int RAM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_error,
  output logic            stall,
  output logic [WORD-1:0] ram_addr,
  output logic            ram_read,
  output logic            ram_write,
  output logic [WORD-1:0] ram_wdata,
  input  logic [WORD-1:0] ram_rdata
);

  localparam int CNT_W = 2;

  state_t           state_q;
  logic [WORD-1:0]  addr_q;
  logic [WORD-1:0]  wdata_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WORD-1:0]  buf_q;
  logic [WORD-1:0]  buf_d;
  logic [WORD-1:0]  rdata_q;
  logic [WORD-1:0]  ram_wdata_q;
  logic             ram_read_q;
  logic             ram_write_q;
  logic             resp_valid_q;
  logic             resp_error_q;
  logic             capture;
  logic [WORD-1:0]  merged;
  logic [WORD-1:0]  extracted;

  // Lane logic sees the doubleword in the same cycle it is captured, so the
  // merge/extract result can be registered straight out of WAIT.
  assign capture = (state_q == ST_WAIT) && (cnt_q == '0);
  assign buf_d   = capture ? ram_rdata : buf_q;

  lane_merge #(.WORD(WORD)) u_lane_merge (
    .buffer_i (buf_d),
    .wdata_i  (wdata_q),
    .offset_i (addr_q[2:0]),
    .size_i   (size_q),
    .merged_o (merged),
    .load_o   (extracted)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= SZ_B;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      buf_q        <= '0;
      rdata_q      <= '0;
      ram_wdata_q  <= '0;
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            write_q <= req_write;
            if (is_misaligned(req_addr[2:0], req_size)) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              rdata_q      <= '0;
            end else if (req_write && (req_size == SZ_D)) begin
              state_q     <= ST_WRITE;
              ram_write_q <= 1'b1;
              ram_wdata_q <= req_wdata;
            end else begin
              state_q    <= ST_READ;
              ram_read_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          cnt_q   <= CNT_W'(RAM_LATENCY - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            if (write_q) begin
              state_q     <= ST_WRITE;
              ram_write_q <= 1'b1;
              ram_wdata_q <= merged;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= extracted;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WRITE: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          rdata_q      <= '0;
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_error_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign stall      = (req_valid && req_ready) || (state_q == ST_READ)
                    || (state_q == ST_WAIT) || (state_q == ST_WRITE);
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = rdata_q;
  assign ram_addr   = {addr_q[WORD-1:3], 3'b000};
  assign ram_read   = ram_read_q;
  assign ram_write  = ram_write_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_controller.sv
// ----------------------------------------------------------------------------
// tb_mem_access_controller: lane_merge vector table, directed sequences and
// randomized traffic against a byte-array memory model. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_controller;

  localparam int LAT   = 3;
  localparam int BOUND = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_error, stall;
  logic [63:0] resp_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        ram_read, ram_write;

  logic [63:0] lm_buf, lm_wd, lm_merged, lm_load;
  logic [2:0]  lm_off;
  logic [1:0]  lm_sz;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_access_controller #(.WORD(64), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .stall(stall), .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  lane_merge #(.WORD(64)) u_lm (
    .buffer_i(lm_buf), .wdata_i(lm_wd), .offset_i(lm_off), .size_i(lm_sz),
    .merged_o(lm_merged), .load_o(lm_load)
  );

  // Doubleword RAM with LAT-cycle read pipeline; junk is presented when no data is due.
  logic [63:0] ram [32];
  logic [63:0] rd_d [LAT];
  logic        rd_v [LAT];
  logic        ram_clr;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) ram[i] <= '0;
    end else if (ram_write) begin
      ram[ram_addr[7:3]] <= ram_wdata;
    end
    for (int k = LAT - 1; k > 0; k--) begin
      rd_d[k] <= rd_d[k-1];
      rd_v[k] <= rd_v[k-1];
    end
    rd_d[0] <= ram[ram_addr[7:3]];
    rd_v[0] <= ram_read;
  end

  assign ram_rdata = rd_v[LAT-1] ? rd_d[LAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;

  // Reference model: flat byte memory.
  logic [7:0] ref_mem [256];

  function automatic logic [63:0] ref_dword(input int base);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[(base & ~7) + i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic [63:0] last_wr, last_rd;

  task automatic run_req(input logic w, input logic [1:0] sz, input logic [63:0] addr,
                         input logic [63:0] wd, input logic hold);
    int          a, nb, exp_lat, lat, n_rd, n_wr;
    logic        mis, seen, err, stall_ok, addr_ok;
    logic [63:0] exp_rd, exp_wr, wr_val, rd_val;
    a       = int'(addr[7:0]);
    nb      = 1 << sz;
    mis     = (a % nb) != 0;
    exp_lat = mis ? 1 : (w && sz == 2'd3) ? 2 : w ? 3 + LAT : 2 + LAT;
    exp_rd  = '0;
    if (!mis && !w) for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = ref_mem[a + i];
    if (!mis && w)  for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
    exp_wr = ref_dword(a);

    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = addr; req_wdata = wd;
    #1;
    stall_ok = (stall === 1'b1) && (req_ready === 1'b1);
    addr_ok = 1'b1; seen = 1'b0; err = 1'b0; lat = 0; n_rd = 0; n_wr = 0;
    wr_val = '0; rd_val = '0;
    for (int c = 1; c <= BOUND && !seen; c++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (ram_read)  begin n_rd++; if (ram_addr !== {addr[63:3], 3'b000}) addr_ok = 1'b0; end
      if (ram_write) begin n_wr++; wr_val = ram_wdata;
                           if (ram_addr !== {addr[63:3], 3'b000}) addr_ok = 1'b0; end
      if (ram_read && ram_write) addr_ok = 1'b0;
      if (resp_valid) begin
        seen = 1'b1; lat = c; err = resp_error; rd_val = resp_rdata;
        if (stall !== 1'b0) stall_ok = 1'b0;
      end else if (stall !== 1'b1) stall_ok = 1'b0;
    end
    req_valid = 1'b0;
    chk("resp_seen",   64'(seen), 64'd1);
    chk("latency",     64'(lat), 64'(exp_lat));
    chk("resp_error",  64'(err), 64'(mis));
    chk("resp_rdata",  rd_val, exp_rd);
    chk("stall_shape", 64'(stall_ok), 64'd1);
    chk("ram_addr",    64'(addr_ok), 64'd1);
    chk("n_reads",     64'(n_rd), (!mis && !(w && sz == 2'd3)) ? 64'd1 : 64'd0);
    chk("n_writes",    64'(n_wr), (!mis && w) ? 64'd1 : 64'd0);
    if (!mis && w) chk("ram_wdata", wr_val, exp_wr);
    @(negedge clk);
    chk("idle_after",  {62'd0, req_ready, resp_valid}, 64'd2);
    last_wr = wr_val;
    last_rd = rd_val;
  endtask

  typedef struct {
    logic [63:0] bufv;
    logic [63:0] wd;
    logic [2:0]  off;
    logic [1:0]  sz;
    logic [63:0] exp_m;
    logic [63:0] exp_l;
  } lm_vec_t;

  lm_vec_t vt [10];

  initial begin
    vt[0] = '{64'h1122334455667788, 64'h00000000000000AB, 3'd3, 2'd0, 64'h11223344AB667788, 64'h55};
    vt[1] = '{64'h1122334455667788, 64'hCAFEBABEDEADBEEF, 3'd0, 2'd3, 64'hCAFEBABEDEADBEEF, 64'h1122334455667788};
    vt[2] = '{64'h1122334455667788, 64'hFFFFFFFFFFFFBEEF, 3'd4, 2'd1, 64'h1122BEEF55667788, 64'h3344};
    vt[3] = '{64'h1122334455667788, 64'h123456789ABCDEF0, 3'd4, 2'd2, 64'h9ABCDEF055667788, 64'h11223344};
    vt[4] = '{64'h1122334455667788, 64'h000000000000A5A5, 3'd6, 2'd1, 64'hA5A5334455667788, 64'h1122};
    vt[5] = '{64'h1122334455667788, 64'h0000000000000000, 3'd7, 2'd0, 64'h0022334455667788, 64'h11};
    vt[6] = '{64'h1122334455667788, 64'h00000000000001FF, 3'd0, 2'd0, 64'h11223344556677FF, 64'h88};
    vt[7] = '{64'hFFEEDDCCBBAA9988, 64'h0000000000000000, 3'd4, 2'd1, 64'hFFEE0000BBAA9988, 64'hDDCC};
    vt[8] = '{64'h1122334455667788, 64'h0000000000001234, 3'd2, 2'd1, 64'h1122334412347788, 64'h5566};
    vt[9] = '{64'h1122334455667788, 64'h00000000FFFFFFFF, 3'd0, 2'd2, 64'h11223344FFFFFFFF, 64'h55667788};

    reset = 1'b1; ram_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    lm_buf = '0; lm_wd = '0; lm_off = '0; lm_sz = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    for (int i = 0; i < 10; i++) begin
      lm_buf = vt[i].bufv; lm_wd = vt[i].wd; lm_off = vt[i].off; lm_sz = vt[i].sz;
      #1;
      chk($sformatf("lm_merge[%0d]", i), lm_merged, vt[i].exp_m);
      chk($sformatf("lm_load[%0d]", i),  lm_load,   vt[i].exp_l);
    end

    repeat (2) @(negedge clk);
    chk("rst_ready",   64'(req_ready), 64'd1);
    chk("rst_strobes", {59'd0, resp_valid, resp_error, stall, ram_read, ram_write}, 64'd0);
    chk("rst_values",  ram_addr | ram_wdata | resp_rdata, 64'd0);
    reset = 1'b0; ram_clr = 1'b0;

    // Directed sequences from the plan.
    run_req(1'b1, 2'd3, 64'h10, 64'h1122334455667788, 1'b0);
    chk("plan_dword_store", last_wr, 64'h1122334455667788);
    run_req(1'b1, 2'd0, 64'h13, 64'h00000000000000AB, 1'b0);
    chk("plan_byte_rmw", last_wr, 64'h11223344AB667788);
    run_req(1'b1, 2'd3, 64'h18, 64'hFFEEDDCCBBAA9988, 1'b0);
    run_req(1'b0, 2'd1, 64'h1C, 64'h0, 1'b0);
    chk("plan_half_load", last_rd, 64'h000000000000DDCC);
    run_req(1'b0, 2'd2, 64'h22, 64'h0, 1'b0);
    run_req(1'b1, 2'd3, 64'h28, 64'h0123456789ABCDEF, 1'b0);
    run_req(1'b0, 2'd2, 64'h2C, 64'h0, 1'b1);
    chk("plan_word_load", last_rd, 64'h0000000001234567);

    // Reset while a byte-store RMW is waiting on read data.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 64'h13; req_wdata = 64'hCD;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midop_stall", 64'(stall), 64'd1);
    reset = 1'b1;
    #1;
    chk("midop_ready",   64'(req_ready), 64'd1);
    chk("midop_strobes", {59'd0, resp_valid, resp_error, stall, ram_read, ram_write}, 64'd0);
    chk("midop_values",  ram_addr | ram_wdata | resp_rdata, 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    chk("midop_ram_kept", ram[2], 64'h11223344AB667788);
    run_req(1'b0, 2'd3, 64'h10, 64'h0, 1'b0);
    chk("midop_reload", last_rd, 64'h11223344AB667788);

    // Randomized traffic checked against the byte-array model.
    for (int t = 0; t < 80; t++) begin
      logic [1:0]  sz;
      logic [63:0] ad;
      sz = 2'($urandom_range(0, 3));
      ad = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((64'd1 << sz) - 64'd1);
      run_req(1'($urandom_range(0, 1)), sz, ad, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    for (int i = 0; i < 32; i++) chk($sformatf("final_ram[%0d]", i), ram[i], ref_dword(i * 8));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
